// File: rtl/inv_key_expansion.sv
// One step of the AES key schedule run backwards: from Nk round-key words,
// recover the preceding Nk words. The datapath is combinational and feeds one output register.
module inv_key_expansion (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] W_enq,
  input  logic [1:0]   algo,
  input  logic [3:0]   Rcon,
  output logic [255:0] W_deq
);

  typedef enum logic [1:0] {
    AES_128  = 2'b00,
    AES_192  = 2'b01,
    AES_256  = 2'b10,
    AES_RSVD = 2'b11
  } algo_e;

  // Forward FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rc_byte(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  algo_e         mode;
  int            nk;
  logic [31:0]   in_w [8];
  logic [31:0]   p    [8];
  logic [31:0]   last_w;
  logic [255:0]  w_next;

  assign mode = algo_e'(algo);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    nk     = 4;
    last_w = '0;
    w_next = '0;
    for (int k = 0; k < 8; k++) begin
      in_w[k] = W_enq[255 - 32*k -: 32];
      p[k]    = '0;
    end

    case (mode)
      AES_192: nk = 6;
      AES_256: nk = 8;
      default: nk = 4;
    endcase

    // Words beyond Nk stay zero, which also drops any unused input words.
    for (int k = 1; k < 8; k++) begin
      if (k < nk) p[k] = in_w[k] ^ in_w[k-1];
    end
    if (mode == AES_256) p[4] = in_w[4] ^ sub_word(in_w[3]);

    case (mode)
      AES_192: last_w = p[5];
      AES_256: last_w = p[7];
      default: last_w = p[3];
    endcase
    p[0] = in_w[0] ^ sub_word(rot_word(last_w)) ^ {rc_byte(Rcon), 24'h0};

    if (mode != AES_RSVD) begin
      for (int k = 0; k < 8; k++) w_next[255 - 32*k -: 32] = p[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) W_deq <= '0;
    else        W_deq <= w_next;
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench for inv_key_expansion. Random previous keys are expanded forward with a
// GF(2^8)-derived reference, and the DUT must recover them.
module tb_inv_key_expansion;

  logic         clk;
  logic         rst_n;
  logic [255:0] W_enq;
  logic [1:0]   algo;
  logic [3:0]   Rcon;
  logic [255:0] W_deq;

  inv_key_expansion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W_enq (W_enq),
    .algo  (algo),
    .Rcon  (Rcon),
    .W_deq (W_deq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] exp;
    string        name;
  } sb_t;

  sb_t        sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sbox_tab [256];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference S-box: multiplicative inverse in GF(2^8) followed by the affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] ref_sub(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Round constant as successive powers of x in GF(2^8).
  function automatic logic [7:0] ref_rc(input int i);
    logic [7:0] r = 8'h01;
    if (i < 1 || i > 10) return 8'h00;
    for (int k = 1; k < i; k++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  task automatic drive(input logic [255:0] w, input logic [1:0] a, input logic [3:0] r,
                       input logic [255:0] exp, input string name);
    sb_t e;
    @(negedge clk);
    W_enq = w;
    algo  = a;
    Rcon  = r;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Pick a random previous key, expand it forward, and expect the DUT to undo that step.
  task automatic run_random(input int idx);
    logic [31:0]  p [8];
    logic [31:0]  w [16];
    logic [31:0]  t;
    logic [255:0] win;
    logic [255:0] exp;
    int           a  = $urandom_range(0, 3);
    int           r  = $urandom_range(0, 15);
    int           nk = 4 + 2 * a;
    for (int k = 0; k < 8; k++) win[255 - 32*k -: 32] = $urandom();
    exp = '0;
    if (a != 3) begin
      for (int k = 0; k < nk; k++) begin
        p[k] = $urandom();
        w[k] = p[k];
      end
      for (int i = nk; i < 2 * nk; i++) begin
        t = w[i-1];
        if (i == nk)                 t = ref_sub({t[23:0], t[31:24]}) ^ {ref_rc(r), 24'h0};
        else if (nk == 8 && i == 12) t = ref_sub(t);
        w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k < nk; k++) begin
        win[255 - 32*k -: 32] = w[nk + k];
        exp[255 - 32*k -: 32] = p[k];
      end
    end
    drive(win, 2'(a), 4'(r), exp, $sformatf("rand%0d_algo%0d_rcon%0d", idx, a, r));
  endtask

  // Monitor: the output register updates every cycle; compare one queued expectation per edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, W_deq, e.exp);
      end
    end
  end

  localparam logic [255:0] V128_IN  = {128'ha0fafe1788542cb123a339392a6c7605, 128'h0};
  localparam logic [255:0] V128_OUT = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] V192_IN  =
    {192'hfe0c91f72402f5a5ec12068e6c827f6b0e7a95b95c56fec2, 64'h0};
  localparam logic [255:0] V192_OUT =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] V256_IN  =
    256'h9ba354118e6925afa51a8b5f2067fcdea8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [255:0] V256_OUT =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] V128R10_IN  = {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0};
  localparam logic [255:0] V128R10_OUT = {128'hac7766f319fadc2128d12941575c006e, 128'h0};
  localparam logic [255:0] V128R0_OUT  = {128'h2a7e151628aed2a6abf7158809cf4f3c, 128'h0};

  initial begin
    logic [255:0] junk;
    rst_n = 1'b0;
    W_enq = V256_IN;
    algo  = 2'b10;
    Rcon  = 4'd1;
    build_sbox();
    #2;
    check("reset_state", W_deq, '0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", W_deq, '0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(V128_IN,     2'b00, 4'd1,  V128_OUT,    "aes128_rcon1");
    drive(V192_IN,     2'b01, 4'd1,  V192_OUT,    "aes192_rcon1");
    drive(V256_IN,     2'b10, 4'd1,  V256_OUT,    "aes256_rcon1");
    drive(V128R10_IN,  2'b00, 4'd10, V128R10_OUT, "aes128_rcon10");
    drive(V128_IN,     2'b00, 4'd0,  V128R0_OUT,  "aes128_rcon0");
    drive(V128_IN,     2'b00, 4'd13, V128R0_OUT,  "aes128_rcon13");
    junk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
    drive({V128_IN[255:128], junk[127:0]}, 2'b00, 4'd1, V128_OUT, "aes128_ignore_low");
    drive({V192_IN[255:64],  junk[63:0]},  2'b01, 4'd1, V192_OUT, "aes192_ignore_low");
    drive(V256_IN,     2'b11, 4'd1,  '0,          "reserved_algo_v256");
    drive(junk,        2'b11, 4'd7,  '0,          "reserved_algo_rand");
    for (int i = 0; i < 60; i++) run_random(i);

    // Reset mid-stream: a pending result must be discarded and the output forced low at once.
    drive(V256_IN, 2'b10, 4'd1, V256_OUT, "pre_reset_aes256");
    @(negedge clk);
    W_enq = V128_IN;
    algo  = 2'b00;
    Rcon  = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", W_deq, '0);
    @(posedge clk);
    #1;
    check("reset_discards_pending", W_deq, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("released_before_edge", W_deq, '0);
    begin
      sb_t e;
      e.exp  = V128_OUT;
      e.name = "first_after_release";
      sb_q.push_back(e);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
